port_pkt_collector: RTL and testbench

//  Downstream of the 16-port arbitrator: on grant (i_en, i_sel), muxes the selected port's beat

---
 rtl/port_pkt_collector.sv | 215 +++++++++++++++++++++
 tb/tb_port_pkt_collector.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_pkt_collector.sv
// ---------------------------------------------------------------------------
// port_pkt_collector
//
// Sits behind the 16-port arbitrator. When a grant arrives (i_en, i_sel) the
// granted port index is latched and that port's beat stream is forwarded onto
// a single registered cache write bus. Written beats are counted. At packet
// end a one-cycle o_eop releases the grant, together with o_pkt_done and the
// final length. Packets longer than MAX_BEATS are cut: the MAX_BEATS-th beat
// is flagged as last, the rest of the packet is drained (acked, not written)
// and o_err_len is reported. Losing the grant mid-packet raises o_wr_abort.
//
// Optional feature, selected with the macro PKT_TIMEOUT_EN:
//   defined   - an idle counter in RECV/DROP aborts the packet and releases
//               the grant after TIMEOUT_CYC cycles without an accepted beat.
//   undefined - RECV/DROP wait for beats indefinitely.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en, i_sel    grant and granted port index from the arbitrator
//   i_data         all ports' beats, port p at [p*DATA_W +: DATA_W]
//   i_vld, i_last  per-port beat valid / last-beat flag
//   o_ack          per-port beat accept (only the latched port can be acked)
//   i_wr_ready     cache write side can take a beat
//   o_wr_en/_data/_sop/_last/_abort   registered cache write bus
//   o_eop          one-cycle grant release towards the arbitrator
//   o_pkt_len, o_pkt_done, o_err_len  packet completion report
// ---------------------------------------------------------------------------
module port_pkt_collector #(
    parameter int PORTNUM     = 16,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 10,
    parameter int MAX_BEATS   = 512,
    parameter int TIMEOUT_CYC = 255,
    localparam int SEL_W      = (PORTNUM > 1) ? $clog2(PORTNUM) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [PORTNUM*DATA_W-1:0] i_data,
    input  logic [PORTNUM-1:0]        i_vld,
    input  logic [PORTNUM-1:0]        i_last,
    output logic [PORTNUM-1:0]        o_ack,
    input  logic                      i_wr_ready,
    output logic                      o_wr_en,
    output logic [DATA_W-1:0]         o_wr_data,
    output logic                      o_wr_sop,
    output logic                      o_wr_last,
    output logic                      o_wr_abort,
    output logic                      o_eop,
    output logic [LEN_W-1:0]          o_pkt_len,
    output logic                      o_pkt_done,
    output logic                      o_err_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_DROP,
        S_EOP,
        S_WAIT
    } state_t;

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_BEATS - 1);

    state_t             state;
    logic [SEL_W-1:0]   sel_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic               err_q;

    logic               sel_ack;
    logic               sel_vld;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               accept;
    logic               timeout_hit;

    // Beat handshake on the latched port. In DROP the tail is discarded, so
    // it is acked regardless of the write side's readiness.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        o_ack    = '0;
        sel_ack  = ((state == S_RECV) && i_wr_ready) || (state == S_DROP);
        sel_vld  = i_vld[sel_q];
        sel_last = i_last[sel_q];
        sel_data = i_data[int'(sel_q) * DATA_W +: DATA_W];
        o_ack[sel_q] = sel_ack;
        accept   = sel_ack && sel_vld;
    end

`ifdef PKT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt;

    // Counts consecutive cycles without an accepted beat while a packet is
    // open; any accept restarts the count. The counter cannot wrap because
    // hitting the limit leaves RECV/DROP.
    always_ff @(posedge i_clk) begin
        if (i_rst || accept || !((state == S_RECV) || (state == S_DROP))) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = ((state == S_RECV) || (state == S_DROP)) && !accept &&
                         (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch sees the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            sel_q      <= '0;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_data  <= '0;
            o_wr_sop   <= 1'b0;
            o_wr_last  <= 1'b0;
            o_wr_abort <= 1'b0;
            o_eop      <= 1'b0;
            o_pkt_len  <= '0;
            o_pkt_done <= 1'b0;
            o_err_len  <= 1'b0;
        end else begin
            // Pulse outputs default low; they are raised for exactly one cycle.
            o_wr_en    <= 1'b0;
            o_wr_sop   <= 1'b0;
            o_wr_last  <= 1'b0;
            o_wr_abort <= 1'b0;
            o_eop      <= 1'b0;
            o_pkt_done <= 1'b0;

            // Write path: only beats accepted in RECV are written. The
            // MAX_BEATS-th beat is marked last even when the source is not
            // done, so the cache sees a closed (truncated) packet.
            if (accept && (state == S_RECV)) begin
                o_wr_en   <= 1'b1;
                o_wr_data <= sel_data;
                o_wr_sop  <= (beat_cnt == '0);
                o_wr_last <= sel_last || (beat_cnt == LAST_IDX);
                beat_cnt  <= beat_cnt + LEN_W'(1);
            end

            unique case (state)
                S_IDLE: begin
                    if (i_en) begin
                        state    <= S_RECV;
                        sel_q    <= i_sel;
                        beat_cnt <= '0;
                        err_q    <= 1'b0;
                    end
                end

                // A last beat accepted in the same cycle the grant drops still
                // completes the packet, so EOP is checked before grant loss.
                S_RECV: begin
                    if (accept && sel_last) begin
                        state <= S_EOP;
                    end else if (!i_en) begin
                        o_wr_abort <= 1'b1;
                        state      <= S_IDLE;
                    end else if (accept && (beat_cnt == LAST_IDX)) begin
                        err_q <= 1'b1;
                        state <= S_DROP;
                    end else if (timeout_hit) begin
                        o_wr_abort <= 1'b1;
                        o_eop      <= 1'b1;
                        state      <= S_WAIT;
                    end
                end

                S_DROP: begin
                    if (accept && sel_last) begin
                        state <= S_EOP;
                    end else if (!i_en) begin
                        o_wr_abort <= 1'b1;
                        state      <= S_IDLE;
                    end else if (timeout_hit) begin
                        o_wr_abort <= 1'b1;
                        o_eop      <= 1'b1;
                        state      <= S_WAIT;
                    end
                end

                S_EOP: begin
                    o_eop      <= 1'b1;
                    o_pkt_done <= 1'b1;
                    o_pkt_len  <= beat_cnt;
                    o_err_len  <= err_q;
                    state      <= S_WAIT;
                end

                // The arbitrator drops i_en one cycle after o_eop; holding
                // here stops the still-asserted grant from opening a new packet.
                S_WAIT: begin
                    if (!i_en) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_port_pkt_collector.sv
// ---------------------------------------------------------------------------
// tb_port_pkt_collector
//
// Randomised bench for port_pkt_collector. A driver plays the granted port
// (with bubbles, write-side stalls and noise on the other ports) and, at the
// moment a packet is issued, pushes the expected written beats and completion
// report into scoreboard queues. Expected values follow the packet rules
// directly: the first min(n, MAX_BEATS) beats are written, sop on the first,
// last on the final or MAX_BEATS-th, error when n > MAX_BEATS. A monitor
// compares whatever the DUT presents against the queue heads.
// ---------------------------------------------------------------------------
module tb_port_pkt_collector;

    localparam int PORTNUM     = 16;
    localparam int DATA_W      = 32;
    localparam int LEN_W       = 10;
    localparam int MAX_BEATS   = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int SEL_W       = 4;

    logic                      i_clk = 1'b0;
    logic                      i_rst = 1'b1;
    logic                      i_en = 1'b0;
    logic [SEL_W-1:0]          i_sel = '0;
    logic [PORTNUM*DATA_W-1:0] i_data = '0;
    logic [PORTNUM-1:0]        i_vld = '0;
    logic [PORTNUM-1:0]        i_last = '0;
    logic                      i_wr_ready = 1'b1;
    logic [PORTNUM-1:0]        o_ack;
    logic                      o_wr_en;
    logic [DATA_W-1:0]         o_wr_data;
    logic                      o_wr_sop;
    logic                      o_wr_last;
    logic                      o_wr_abort;
    logic                      o_eop;
    logic [LEN_W-1:0]          o_pkt_len;
    logic                      o_pkt_done;
    logic                      o_err_len;

    port_pkt_collector #(
        .PORTNUM    (PORTNUM),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .MAX_BEATS  (MAX_BEATS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_sel      (i_sel),
        .i_data     (i_data),
        .i_vld      (i_vld),
        .i_last     (i_last),
        .o_ack      (o_ack),
        .i_wr_ready (i_wr_ready),
        .o_wr_en    (o_wr_en),
        .o_wr_data  (o_wr_data),
        .o_wr_sop   (o_wr_sop),
        .o_wr_last  (o_wr_last),
        .o_wr_abort (o_wr_abort),
        .o_eop      (o_eop),
        .o_pkt_len  (o_pkt_len),
        .o_pkt_done (o_pkt_done),
        .o_err_len  (o_err_len)
    );

    always #5 i_clk = ~i_clk;

    typedef enum {M_NORMAL, M_ABORT, M_RESET, M_TIMEOUT, M_EOPWIN} mode_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                sop;
        bit                last;
    } wr_t;

    typedef struct {
        bit done;
        int len;
        bit err;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    exp_abort  = 0;
    int    abort_seen = 0;
    int    cur_port   = 0;
    bit    mon_en     = 1'b0;
    int    n_checks   = 0;
    int    n_fail     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        @(negedge i_clk);
        check({tag, "_ack"},      o_ack,      0);
        check({tag, "_wr_en"},    o_wr_en,    0);
        check({tag, "_wr_data"},  o_wr_data,  0);
        check({tag, "_wr_sop"},   o_wr_sop,   0);
        check({tag, "_wr_last"},  o_wr_last,  0);
        check({tag, "_wr_abort"}, o_wr_abort, 0);
        check({tag, "_eop"},      o_eop,      0);
        check({tag, "_pkt_len"},  o_pkt_len,  0);
        check({tag, "_pkt_done"}, o_pkt_done, 0);
        check({tag, "_err_len"},  o_err_len,  0);
    endtask

    // Monitor: compares every DUT output event against the scoreboard.
    initial begin
        forever begin
            @(negedge i_clk);
            if (mon_en) begin
                if (o_ack != '0) begin
                    check("ack_only_granted", o_ack & ~(PORTNUM'(1) << cur_port), 0);
                end
                if (o_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", o_wr_en, 0);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        check("wr_data", o_wr_data, e.data);
                        check("wr_sop",  o_wr_sop,  e.sop);
                        check("wr_last", o_wr_last, e.last);
                    end
                end
                if (o_eop || o_pkt_done) begin
                    if (exp_done.size() == 0) begin
                        check("done_unexpected", {o_eop, o_pkt_done}, 0);
                    end else begin
                        done_t d;
                        d = exp_done.pop_front();
                        check("eop",      o_eop,      1);
                        check("pkt_done", o_pkt_done, d.done);
                        if (d.done) begin
                            check("pkt_len", o_pkt_len, d.len);
                            check("err_len", o_err_len, d.err);
                        end
                    end
                end
                if (o_wr_abort) begin
                    abort_seen++;
                    if (abort_seen > exp_abort) begin
                        check("abort_unexpected", abort_seen, exp_abort);
                    end
                end
            end
        end
    end

    // Drives one packet of nbeats on port. cut = number of beats accepted
    // before the grant is pulled / reset applied / source stalls.
    task automatic send_pkt(input int port, input int nbeats, input mode_t mode,
                            input int cut, input bit stall, input logic [DATA_W-1:0] base);
        int lim;
        int nwr;
        int k;
        int budget;
        int stall_left;
        bit acc;
        bit seen;

        lim = (mode == M_NORMAL || mode == M_EOPWIN) ? nbeats : cut;
        nwr = (lim < MAX_BEATS) ? lim : MAX_BEATS;
        for (int b = 0; b < nwr; b++) begin
            exp_wr.push_back('{data: base + DATA_W'(b), sop: (b == 0),
                               last: (b == nbeats - 1) || (b == MAX_BEATS - 1)});
        end
        case (mode)
            M_NORMAL, M_EOPWIN: exp_done.push_back('{done: 1'b1, len: nwr, err: (nbeats > MAX_BEATS)});
            M_ABORT:            exp_abort++;
            M_TIMEOUT: begin
                exp_abort++;
                exp_done.push_back('{done: 1'b0, len: 0, err: 1'b0});
            end
            default: ;
        endcase

        cur_port   = port;
        i_sel      = SEL_W'(port);
        i_en       = 1'b1;
        k          = 0;
        budget     = 0;
        stall_left = stall ? 3 : 0;
        while (k < lim && budget < 300) begin
            for (int p = 0; p < PORTNUM; p++) begin
                i_data[p*DATA_W +: DATA_W] = $urandom;
            end
            i_vld  = PORTNUM'($urandom);
            i_last = PORTNUM'($urandom);
            // The grant index is latched, so later i_sel changes must be ignored.
            if (budget > 0) i_sel = SEL_W'($urandom_range(PORTNUM - 1));
            i_vld[port]  = ($urandom_range(3) != 0);
            i_data[port*DATA_W +: DATA_W] = base + DATA_W'(k);
            i_last[port] = (k == nbeats - 1);
            i_wr_ready   = ($urandom_range(7) != 0);
            if (stall_left > 0 && k == 2 && budget > 0) begin
                i_wr_ready  = 1'b0;
                i_vld[port] = 1'b1;
                stall_left--;
            end
            if (mode == M_EOPWIN && k == nbeats - 1 && budget > 0) begin
                i_vld[port] = 1'b1;
                i_wr_ready  = 1'b1;
                i_en        = 1'b0;
            end
            @(negedge i_clk);
            if (k < MAX_BEATS && !i_wr_ready) begin
                check("ack_when_not_ready", o_ack[port], 0);
            end
            acc = i_vld[port] && o_ack[port];
            step();
            if (acc) k++;
            budget++;
        end
        if (k < lim) check("beat_budget", k, lim);
        i_vld      = '0;
        i_last     = '0;
        i_wr_ready = 1'b1;

        case (mode)
            M_ABORT: begin
                i_en = 1'b0;
                step();
            end
            M_RESET: begin
                i_rst = 1'b1;
                step();
                check_zero("mid_reset");
                i_rst = 1'b0;
                i_en  = 1'b0;
                step();
            end
            default: begin
                seen = 1'b0;
                for (int c = 0; c < 40 && !seen; c++) begin
                    @(negedge i_clk);
                    seen = o_eop;
                end
                if (!seen) check("eop_wait", o_eop, 1);
                step();
                i_en = 1'b0;
            end
        endcase
        step();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        step();
        step();
        check_zero("reset");
        mon_en = 1'b1;
        step();
        i_rst = 1'b0;
        step();

        // Directed scenarios.
        send_pkt(3,  4,  M_NORMAL, 0, 1'b0, 32'h0000_00A0);   // basic 4-beat packet
        send_pkt(0,  12, M_NORMAL, 0, 1'b0, $urandom);       // truncation + drain
        send_pkt(7,  6,  M_NORMAL, 0, 1'b1, $urandom);       // 3-cycle write stall
        send_pkt(15, 5,  M_ABORT,  2, 1'b0, $urandom);       // grant lost after 2 beats
        send_pkt(9,  4,  M_NORMAL, 0, 1'b0, $urandom);       // next grant works
        send_pkt(2,  6,  M_RESET,  3, 1'b0, $urandom);       // reset mid-packet
        send_pkt(4,  3,  M_NORMAL, 0, 1'b0, $urandom);       // clean sop after reset
        send_pkt(6,  3,  M_EOPWIN, 0, 1'b0, $urandom);       // last beat with grant drop
        send_pkt(1,  8,  M_NORMAL, 0, 1'b0, $urandom);       // exactly MAX_BEATS
        send_pkt(1,  9,  M_NORMAL, 0, 1'b0, $urandom);       // one over MAX_BEATS
        send_pkt(12, 1,  M_NORMAL, 0, 1'b0, $urandom);       // single beat
`ifdef PKT_TIMEOUT_EN
        send_pkt(5,  4,  M_TIMEOUT, 1, 1'b0, $urandom);      // source stalls after 1 beat
`endif

        // Randomised packets.
        for (int i = 0; i < 30; i++) begin
            int p;
            int n;
            p = $urandom_range(PORTNUM - 1);
            n = $urandom_range(12, 1);
            if (n >= 2 && $urandom_range(4) == 0) begin
                send_pkt(p, n, M_ABORT, $urandom_range((n - 1 < MAX_BEATS) ? n - 1 : MAX_BEATS, 1),
                         1'b0, $urandom);
            end else begin
                send_pkt(p, n, M_NORMAL, 0, ($urandom_range(3) == 0), $urandom);
            end
        end

        repeat (5) step();
        check("wr_queue_empty",   exp_wr.size(),   0);
        check("done_queue_empty", exp_done.size(), 0);
        check("abort_count",      abort_seen,      exp_abort);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
